tuner_frame_sequencer: RTL and testbench

Frame-level controller for the tuner's spectral datapath. It sequences one analysis frame at a time: fill the sample FIFO at the audio rate, stream exactly `FRAME_LEN` samples into the FFT core with correct start/end-of-packet framing, then track the FFT output stream. It supplies the bin index that the peak-search stage pairs with each amplitude. It sits between the sample FIFO, the FFT core and the max-amplitude stage, all in the `CLOCK_50` domain.

---
 rtl/tuner_frame_sequencer.sv | 150 +++++++++++++++
 tb/tb_tuner_frame_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tuner_frame_sequencer.sv
// rtl/tuner_frame_sequencer.sv - frame sequencer between sample FIFO, FFT core and peak search
module tuner_frame_sequencer #(
    parameter int FRAME_LEN = 16384,
    parameter int CNT_W     = 15,
    parameter int TIMEOUT   = 65535
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic             buf_empty,
    input  logic             buf_full,
    output logic             fill_req,
    output logic             buf_flush,
    output logic             rdreq,
    input  logic             sink_ready,
    output logic             sink_valid,
    output logic             sink_sop,
    output logic             sink_eop,
    input  logic             source_valid,
    input  logic             source_sop,
    input  logic             source_eop,
    output logic [CNT_W-1:0] bin_index,
    output logic             frame_done,
    output logic             frame_error,
    output logic             busy,
    output logic [15:0]      frame_count
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_LOAD, S_WAIT_OUT, S_DRAIN, S_REPORT, S_FLUSH
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_abort;
    logic             w_beat;
    logic             w_tclr;
    logic             w_tmo;
    logic             w_src_last;
    logic [CNT_W-1:0] r_scnt;
    logic [CNT_W-1:0] r_bin;
    logic [TO_W-1:0]  r_tcnt;
    logic             r_fill_req;
    logic             r_buf_flush;
    logic             r_frame_done;
    logic             r_frame_error;
    logic             r_busy;
    logic [15:0]      r_frame_count;

    // FFT input side is combinational so a beat can issue in the same cycle the FIFO shows data
    assign sink_valid = (r_state == S_LOAD) && !buf_empty;
    assign sink_sop   = sink_valid && (r_scnt == '0);
    assign sink_eop   = sink_valid && (r_scnt == LAST_IDX);
    assign w_beat     = sink_valid && sink_ready;
    assign rdreq      = w_beat;

    assign w_src_last = (r_bin == LAST_IDX);
    assign w_tmo      = (r_tcnt == TO_LAST);
    assign w_tclr     = source_valid &&
                        ((r_state == S_DRAIN) || (r_state == S_WAIT_OUT && source_sop));

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next = buf_empty ? S_FILL : S_FLUSH;
            end
            S_FILL: begin
                if (buf_full)     w_next = S_LOAD;
                else if (!enable) w_next = S_FLUSH;
            end
            S_LOAD: begin
                if (w_beat && r_scnt == LAST_IDX) w_next = S_WAIT_OUT;
            end
            S_WAIT_OUT: begin
                if (source_valid && source_sop) begin
                    if (source_eop) w_abort = 1'b1;
                    else            w_next  = S_DRAIN;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                end
            end
            S_DRAIN: begin
                // a missing eop on the last bin is an overrun and aborts like a early eop
                if (source_valid) begin
                    if (source_sop || (source_eop != w_src_last)) w_abort = 1'b1;
                    else if (source_eop)                          w_next  = S_REPORT;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                end
            end
            S_REPORT: begin
                if (enable) w_next = buf_empty ? S_FILL : S_FLUSH;
                else        w_next = S_IDLE;
            end
            S_FLUSH: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_FLUSH;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_fill_req    <= 1'b0;
            r_buf_flush   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
            r_scnt        <= '0;
            r_bin         <= '0;
            r_tcnt        <= '0;
        end else begin
            r_state       <= w_next;
            r_fill_req    <= (w_next == S_FILL);
            r_buf_flush   <= (w_next == S_FLUSH);
            r_frame_done  <= (w_next == S_REPORT);
            r_frame_error <= w_abort;
            r_busy        <= (w_next != S_IDLE);
            if (w_next == S_REPORT) r_frame_count <= r_frame_count + 1'b1;

            if (r_state != S_LOAD) r_scnt <= '0;
            else if (w_beat)       r_scnt <= (r_scnt == LAST_IDX) ? '0 : r_scnt + 1'b1;

            if (r_state == S_WAIT_OUT || r_state == S_DRAIN)
                r_tcnt <= w_tclr ? '0 : r_tcnt + 1'b1;
            else
                r_tcnt <= '0;

            if (w_next == S_DRAIN && source_valid)
                r_bin <= r_bin + 1'b1;
            else if (r_state == S_LOAD && w_next == S_WAIT_OUT)
                r_bin <= '0;
        end
    end

    assign fill_req    = r_fill_req;
    assign buf_flush   = r_buf_flush;
    assign frame_done  = r_frame_done;
    assign frame_error = r_frame_error;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;
    assign bin_index   = r_bin;

endmodule

// File: tb/tb_tuner_frame_sequencer.sv
// tb/tb_tuner_frame_sequencer.sv - randomized bench for tuner_frame_sequencer
module tb_tuner_frame_sequencer;
    localparam int FL = 8;
    localparam int CW = 4;
    localparam int TO = 20;

    localparam int M_NOM      = 0;
    localparam int M_BP       = 1;
    localparam int M_RAND     = 2;
    localparam int M_TO       = 3;
    localparam int M_MALF     = 4;
    localparam int M_FILLDROP = 5;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          enable;
    logic          buf_empty;
    logic          buf_full;
    logic          fill_req;
    logic          buf_flush;
    logic          rdreq;
    logic          sink_ready;
    logic          sink_valid;
    logic          sink_sop;
    logic          sink_eop;
    logic          source_valid;
    logic          source_sop;
    logic          source_eop;
    logic [CW-1:0] bin_index;
    logic          frame_done;
    logic          frame_error;
    logic          busy;
    logic [15:0]   frame_count;

    int n_checks = 0;
    int n_errors = 0;
    int fifo_n   = 0;
    int exp_frames = 0;

    tuner_frame_sequencer #(.FRAME_LEN(FL), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .enable       (enable),
        .buf_empty    (buf_empty),
        .buf_full     (buf_full),
        .fill_req     (fill_req),
        .buf_flush    (buf_flush),
        .rdreq        (rdreq),
        .sink_ready   (sink_ready),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .bin_index    (bin_index),
        .frame_done   (frame_done),
        .frame_error  (frame_error),
        .busy         (busy),
        .frame_count  (frame_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fill_req"},    fill_req,    0);
        check({tag, "_buf_flush"},   buf_flush,   0);
        check({tag, "_rdreq"},       rdreq,       0);
        check({tag, "_sink_valid"},  sink_valid,  0);
        check({tag, "_sink_sop"},    sink_sop,    0);
        check({tag, "_sink_eop"},    sink_eop,    0);
        check({tag, "_bin_index"},   bin_index,   0);
        check({tag, "_frame_done"},  frame_done,  0);
        check({tag, "_frame_error"}, frame_error, 0);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_frame_count"}, frame_count, 0);
    endtask

    // One frame against a FIFO occupancy model and an FFT packet model.
    task automatic run_frame(input int mode, input bit keep_en, input int rst_beat);
        int nbeat, src_k, src_start, drove;
        int eop_cyc, err_cyc, done_cyc, full_cyc;
        int done_n, err_n, flush_n;
        bit fft_on, fin, full_seen;
        logic s_rdreq, s_flush, s_fill;
        nbeat = 0; src_k = 0; src_start = 0; drove = -1;
        eop_cyc = -100; err_cyc = -100; done_cyc = -100; full_cyc = -100;
        done_n = 0; err_n = 0; flush_n = 0;
        fft_on = 0; fin = 0; full_seen = 0;
        s_rdreq = 0; s_flush = 0; s_fill = 0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(posedge CLOCK_50);
            #1;
            if (s_rdreq && fifo_n > 0) fifo_n--;
            if (s_flush) fifo_n = 0;
            if (s_fill && fifo_n < FL && $urandom_range(3) != 0) fifo_n++;
            buf_empty = (fifo_n == 0);
            buf_full  = (fifo_n >= FL);
            if (cyc == 0) enable = 1'b1;
            if (mode == M_FILLDROP && fifo_n >= 3) enable = 1'b0;
            case (mode)
                M_NOM:   sink_ready = 1'b1;
                M_BP:    sink_ready = (cyc % 2 == 0);
                default: sink_ready = ($urandom_range(3) != 0);
            endcase
            source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; drove = -1;
            if (fft_on && cyc >= src_start) begin
                if (mode == M_TO) begin
                    source_valid = ($urandom_range(1) == 1);
                end else if (src_k < FL && $urandom_range(3) != 0) begin
                    source_valid = 1'b1;
                    source_sop   = (src_k == 0);
                    source_eop   = (mode == M_MALF) ? (src_k == 5) : (src_k == FL - 1);
                    drove        = src_k;
                    src_k        = source_eop ? FL : src_k + 1;
                end
            end

            @(negedge CLOCK_50);
            if (rst_beat >= 0 && nbeat == rst_beat) begin
                #2 reset = 1'b1;
                #1;
                check_reset_outputs("midreset");
                @(posedge CLOCK_50);
                #1;
                reset = 1'b0; enable = 1'b0; fifo_n = 0; exp_frames = 0;
                buf_empty = 1'b1; buf_full = 1'b0;
                source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
                return;
            end
            s_rdreq = rdreq; s_flush = buf_flush; s_fill = fill_req;
            if (buf_full && !full_seen) begin
                full_seen = 1;
                full_cyc  = cyc;
                check("fill_req_at_full", fill_req, 1);
            end
            if (cyc == full_cyc + 1) check("fill_req_after_full", fill_req, 0);
            if (sink_valid && sink_ready) begin
                check("sink_sop", sink_sop, nbeat == 0);
                check("sink_eop", sink_eop, nbeat == FL - 1);
                check("rdreq_beat", rdreq, 1);
                nbeat++;
                if (nbeat == FL) begin
                    eop_cyc   = cyc;
                    fft_on    = 1;
                    src_start = cyc + 1 + int'($urandom_range(4));
                    if (mode == M_TO) enable = 1'b0;
                end
            end else if (sink_valid) begin
                check("rdreq_stall", rdreq, 0);
            end
            if (drove >= 0) check("bin_index", bin_index, drove);
            if (drove == 3 && !keep_en) enable = 1'b0;
            if (mode == M_TO && source_valid && err_n == 0) check("bin_wait", bin_index, 0);
            if (frame_done)  begin done_n++; done_cyc = cyc; end
            if (frame_error) begin err_n++;  err_cyc  = cyc; end
            if (buf_flush) flush_n++;
            if (keep_en && cyc == done_cyc + 1) begin
                check("refill", fill_req, 1);
                enable = 1'b0;
            end
            if (done_n + err_n + flush_n > 0 && !busy) fin = 1;
        end
        check("budget", fin, 1);
        case (mode)
            M_TO: begin
                check("to_err", err_n, 1);
                check("to_done", done_n, 0);
                check("to_latency", err_cyc - eop_cyc, TO + 1);
                check("to_flush", flush_n, 1);
            end
            M_MALF: begin
                check("malf_err", err_n, 1);
                check("malf_done", done_n, 0);
                check("malf_flush", flush_n, 1);
            end
            M_FILLDROP: begin
                check("fdrop_flush", flush_n, 1);
                check("fdrop_done", done_n, 0);
                check("fdrop_beats", nbeat, 0);
                check("fdrop_fill_req", fill_req, 0);
            end
            default: begin
                check("done", done_n, 1);
                check("err", err_n, 0);
                check("beats", nbeat, FL);
                check("flush", flush_n, keep_en ? 1 : 0);
                exp_frames++;
            end
        endcase
        check("frame_count", frame_count, exp_frames);
        check("busy_end", busy, 0);
        source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; buf_empty = 1'b1; buf_full = 1'b0;
        sink_ready = 1'b0; source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge CLOCK_50);
        #1 reset = 1'b0;

        run_frame(M_NOM,      0, -1);
        run_frame(M_BP,       0, -1);
        run_frame(M_RAND,     1, -1);
        run_frame(M_TO,       0, -1);
        run_frame(M_MALF,     0, -1);
        run_frame(M_FILLDROP, 0, -1);
        run_frame(M_RAND,     0,  3);
        run_frame(M_NOM,      0, -1);
        for (int i = 0; i < 4; i++) run_frame(M_RAND, i % 2 == 1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
